shared_debounce_scheduler: RTL and testbench

Debounces N button inputs using a single shared settle counter instead of one debounce FSM per button. A round-robin arbiter grants the counter to one mismatching button at a time. It times that button's stability and commits its new level. On commit it emits a one-cycle press or release pulse. It sits between the synchronized button inputs and the game/control logic, which consumes `btn_db`, `press_pulse` and `release_pulse`.

---
 rtl/shared_debounce_scheduler.sv | 109 ++++++++++
 tb/tb_shared_debounce_scheduler.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/shared_debounce_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : shared_debounce_scheduler
//  Purpose  : N-button debouncer sharing one settle counter via round-robin
//  Revision : 1.0  initial release
// ============================================================================
module shared_debounce_scheduler #(
    parameter int N     = 4,
    parameter int IW    = 2,
    parameter int COUNT = 3,
    parameter int CW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  btn_raw,
    output logic [N-1:0]  btn_db,
    output logic [N-1:0]  press_pulse,
    output logic [N-1:0]  release_pulse,
    output logic          busy,
    output logic [IW-1:0] active_idx
);

    localparam logic [1:0]    c_idle       = 2'd0;
    localparam logic [1:0]    c_timing     = 2'd1;
    localparam logic [1:0]    c_commit     = 2'd2;
    localparam logic [CW-1:0] c_last_count = CW'(COUNT - 1);

    logic [1:0]    r_state;
    logic [CW-1:0] r_count;
    logic [IW-1:0] r_rr_ptr;
    logic          r_target;

    logic [N-1:0]  w_mismatch;
    logic          w_grant_valid;
    logic [IW-1:0] w_grant_idx;
    logic [IW-1:0] w_cand;
    logic [IW-1:0] w_next_ptr;
    logic [N-1:0]  w_onehot;
    logic          w_sample;

    assign w_mismatch = btn_raw ^ btn_db;
    assign w_sample   = btn_raw[active_idx];
    assign w_next_ptr = IW'((int'(active_idx) + 1) % N);
    assign w_onehot   = N'(1) << active_idx;
    assign busy       = (r_state != c_idle);

    // Descending scan so the candidate closest to rr_ptr (upward, wrapping) wins.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_idx   = '0;
        w_cand        = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_cand = IW'((int'(r_rr_ptr) + k) % N);
            if (w_mismatch[w_cand]) begin
                w_grant_valid = 1'b1;
                w_grant_idx   = w_cand;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= c_idle;
            r_count       <= '0;
            r_rr_ptr      <= '0;
            r_target      <= 1'b0;
            btn_db        <= '0;
            press_pulse   <= '0;
            release_pulse <= '0;
            active_idx    <= '0;
        end else begin
            press_pulse   <= '0;
            release_pulse <= '0;
            case (r_state)
                c_idle: begin
                    if (w_grant_valid) begin
                        active_idx <= w_grant_idx;
                        r_target   <= btn_raw[w_grant_idx];
                        r_count    <= '0;
                        r_state    <= c_timing;
                    end
                end
                c_timing: begin
                    if (w_sample != r_target) begin
                        r_rr_ptr <= w_next_ptr;
                        r_state  <= c_idle;
                    end else if (r_count == c_last_count) begin
                        btn_db[active_idx] <= r_target;
                        if (r_target) begin
                            press_pulse <= w_onehot;
                        end else begin
                            release_pulse <= w_onehot;
                        end
                        r_state <= c_commit;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                c_commit: begin
                    r_rr_ptr <= w_next_ptr;
                    r_state  <= c_idle;
                end
                default: r_state <= c_idle;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_shared_debounce_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shared_debounce_scheduler
//  Purpose  : directed self-checking bench for shared_debounce_scheduler
//  Revision : 1.0  initial release
// ============================================================================
module tb_shared_debounce_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] btn_raw;
    logic [3:0] btn_db;
    logic [3:0] press_pulse;
    logic [3:0] release_pulse;
    logic       busy;
    logic [1:0] active_idx;

    int n_checks = 0;
    int n_errors = 0;

    logic [9:0] bounce_raw  = 10'b1111101101;
    logic [9:0] bounce_busy = 10'b0111101101;
    logic [3:0] exp_press;

    shared_debounce_scheduler #(.N(4), .IW(2), .COUNT(3), .CW(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .btn_raw       (btn_raw),
        .btn_db        (btn_db),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .busy          (busy),
        .active_idx    (active_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [3:0] raw);
        reset   = 1'b1;
        btn_raw = raw;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with all buttons held high, then sequential commits 0..3.
        reset   = 1'b1;
        btn_raw = 4'b1111;
        tick();
        tick();
        check("rst_db",      btn_db,        4'b0000);
        check("rst_press",   press_pulse,   4'b0000);
        check("rst_release", release_pulse, 4'b0000);
        check("rst_busy",    busy,          1'b0);
        check("rst_idx",     active_idx,    2'd0);
        reset = 1'b0;
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (t == 1) begin
                check("rel_busy", busy, 1'b1);
                check("rel_idx",  active_idx, 2'd0);
            end
            exp_press = (t >= 4 && (t - 4) % 5 == 0) ? (4'b0001 << ((t - 4) / 5)) : 4'b0000;
            check("rel_press", press_pulse, exp_press);
        end
        check("rel_db", btn_db, 4'b1111);

        // Clean press and release of button 2.
        do_reset(4'b0000);
        btn_raw = 4'b0100;
        for (int t = 1; t <= 5; t++) begin
            tick();
            if (t == 1) check("press_idx", active_idx, 2'd2);
            check("press_db",    btn_db,      (t >= 4) ? 4'b0100 : 4'b0000);
            check("press_pulse", press_pulse, (t == 4) ? 4'b0100 : 4'b0000);
            check("press_busy",  busy,        (t <= 4) ? 1'b1 : 1'b0);
        end
        btn_raw = 4'b0000;
        for (int t = 1; t <= 5; t++) begin
            tick();
            check("rls_db",    btn_db,        (t >= 4) ? 4'b0000 : 4'b0100);
            check("rls_pulse", release_pulse, (t == 4) ? 4'b0100 : 4'b0000);
            check("rls_press", press_pulse,   4'b0000);
        end

        // Serve button 1 twice so rr_ptr lands on 2, then raise 0 and 3 together.
        btn_raw = 4'b0010;
        repeat (5) tick();
        check("b1_up_db", btn_db, 4'b0010);
        btn_raw = 4'b0000;
        repeat (5) tick();
        check("b1_dn_db", btn_db, 4'b0000);
        btn_raw = 4'b1001;
        for (int t = 1; t <= 10; t++) begin
            tick();
            if (t == 1) check("rr_first_idx",  active_idx, 2'd3);
            if (t == 6) check("rr_second_idx", active_idx, 2'd0);
            exp_press = (t == 4) ? 4'b1000 : (t == 9) ? 4'b0001 : 4'b0000;
            check("rr_press", press_pulse, exp_press);
        end
        check("rr_db", btn_db, 4'b1001);
        btn_raw = 4'b0000;
        repeat (12) tick();
        check("rr_clear_db", btn_db, 4'b0000);

        // Bounce on button 1: aborts, regrants, commits after stable run.
        for (int t = 1; t <= 10; t++) begin
            btn_raw = {2'b00, bounce_raw[t-1], 1'b0};
            tick();
            if (t == 1) check("bnc_idx", active_idx, 2'd1);
            check("bnc_busy",  busy,        bounce_busy[t-1]);
            check("bnc_press", press_pulse, (t == 9) ? 4'b0010 : 4'b0000);
        end
        check("bnc_db", btn_db, 4'b0010);

        // Button 3 toggles every cycle; buttons 0 and 2 still commit.
        for (int t = 1; t <= 14; t++) begin
            btn_raw = {(t % 2 == 0), 3'b111};
            tick();
            if (t == 6) check("starve_idx3", active_idx, 2'd3);
            if (t == 8) check("starve_idx0", active_idx, 2'd0);
            exp_press = (t == 4) ? 4'b0100 : (t == 11) ? 4'b0001 : 4'b0000;
            check("starve_press", press_pulse, exp_press);
        end
        btn_raw = 4'b0111;
        repeat (3) tick();
        check("starve_db",   btn_db, 4'b0111);
        check("starve_busy", busy,   1'b0);

        // Withdrawn request on button 1 while button 0 is timing.
        do_reset(4'b0000);
        btn_raw = 4'b0001;
        for (int t = 1; t <= 7; t++) begin
            if (t == 2) btn_raw[1] = 1'b1;
            if (t == 4) btn_raw[1] = 1'b0;
            tick();
            check("wd_press",   press_pulse,   (t == 4) ? 4'b0001 : 4'b0000);
            check("wd_release", release_pulse, 4'b0000);
        end
        check("wd_db",   btn_db, 4'b0001);
        check("wd_busy", busy,   1'b0);

        // Reset asserted during the commit cycle of button 2.
        btn_raw = 4'b0101;
        for (int t = 1; t <= 4; t++) begin
            tick();
            if (t == 1) check("mid_idx", active_idx, 2'd2);
        end
        check("mid_press_pre", press_pulse, 4'b0100);
        reset = 1'b1;
        #1;
        check("mid_press", press_pulse,   4'b0000);
        check("mid_rel",   release_pulse, 4'b0000);
        check("mid_db",    btn_db,        4'b0000);
        check("mid_busy",  busy,          1'b0);
        tick();
        reset = 1'b0;
        for (int t = 1; t <= 10; t++) begin
            tick();
            if (t == 1) check("redb_idx", active_idx, 2'd0);
            if (t == 6) check("redb_idx2", active_idx, 2'd2);
            exp_press = (t == 4) ? 4'b0001 : (t == 9) ? 4'b0100 : 4'b0000;
            check("redb_press", press_pulse, exp_press);
        end
        check("redb_db", btn_db, 4'b0101);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
